// File: rtl/elm_hidden_loop_seq.sv
// elm_hidden_loop_seq: ELM hidden-layer loop controller; start -> first en_P in 2 cycles.
// Per neuron: clear MAC + sample counter, stream samples until P_stop, drain the MAC
// pipeline, then commit the result. Repeats for NUM_HIDDEN neurons, then pulses done.
// Ports: clk/rst (sync, active-high); start, hold, abort, P_stop in;
//        en_P, rst_P, mac_clr, mac_en, acc_wr, h_index, busy, done out.
// Backpressure: hold freezes sample streaming (en_P/mac_en low) while in RUN only.
module elm_hidden_loop_seq #(
  parameter int NUM_HIDDEN = 16,
  parameter int H_W        = 8,
  parameter int MAC_LAT    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           hold,
  input  logic           abort,
  input  logic           P_stop,
  output logic           en_P,
  output logic           rst_P,
  output logic           mac_clr,
  output logic           mac_en,
  output logic           acc_wr,
  output logic [H_W-1:0] h_index,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  localparam logic [H_W-1:0] H_LAST = H_W'(NUM_HIDDEN - 1);
  localparam logic [3:0]     LAT    = 4'(MAC_LAT);

  state_t         state, state_nxt;
  logic [H_W-1:0] h_nxt;
  logic [3:0]     drain_cnt, drain_nxt;
  // Registered one-shot that resets the sample counter in the IDLE cycle
  // following an abort, keeping rst_P free of any combinational abort path.
  logic           abort_rst, abort_rst_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      h_index   <= '0;
      drain_cnt <= '0;
      abort_rst <= 1'b0;
    end else begin
      state     <= state_nxt;
      h_index   <= h_nxt;
      drain_cnt <= drain_nxt;
      abort_rst <= abort_rst_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    h_nxt         = h_index;
    drain_nxt     = drain_cnt;
    abort_rst_nxt = 1'b0;
    if (abort && state != S_IDLE) begin
      state_nxt     = S_IDLE;
      h_nxt         = '0;
      drain_nxt     = '0;
      abort_rst_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_CLR;
            h_nxt     = '0;
          end
        end
        S_CLR: state_nxt = S_RUN;
        S_RUN: begin
          // P_stop only counts when the sample is actually consumed.
          if (!hold && P_stop) begin
            state_nxt = S_DRAIN;
            drain_nxt = LAT;
          end
        end
        S_DRAIN: begin
          // Loaded with MAC_LAT; leaving at <=1 gives max(MAC_LAT,1) cycles.
          if (drain_cnt <= 4'd1) begin
            state_nxt = S_WRITE;
            drain_nxt = '0;
          end else begin
            drain_nxt = drain_cnt - 4'd1;
          end
        end
        S_WRITE: begin
          if (h_index == H_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_CLR;
            h_nxt     = h_index + 1'b1;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          h_nxt     = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          h_nxt     = '0;
        end
      endcase
    end
  end

  // Pure decodes of registered state (hold gates streaming directly).
  always_comb begin
    en_P    = (state == S_RUN) && !hold;
    mac_en  = (state == S_RUN) && !hold;
    rst_P   = (state == S_CLR) || abort_rst;
    mac_clr = (state == S_CLR);
    acc_wr  = (state == S_WRITE);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

endmodule

// File: tb/tb_elm_hidden_loop_seq.sv
module tb_elm_hidden_loop_seq;

  localparam int NH = 4;
  localparam int ML = 3;
  localparam int DL = (ML > 0) ? ML : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic       P_stop, en_P, rst_P, mac_clr, mac_en, acc_wr, busy, done;
  logic [7:0] h_index;

  logic       b_start = 1'b0, b_zero = 1'b0;
  logic       b_pstop, b_en_P, b_rst_P, b_mac_clr, b_mac_en, b_acc_wr, b_busy, b_done;
  logic [7:0] b_h_index;

  elm_hidden_loop_seq #(.NUM_HIDDEN(NH), .H_W(8), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort), .P_stop(P_stop),
    .en_P(en_P), .rst_P(rst_P), .mac_clr(mac_clr), .mac_en(mac_en), .acc_wr(acc_wr),
    .h_index(h_index), .busy(busy), .done(done));

  elm_hidden_loop_seq #(.NUM_HIDDEN(1), .H_W(8), .MAC_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .hold(b_zero), .abort(b_zero), .P_stop(b_pstop),
    .en_P(b_en_P), .rst_P(b_rst_P), .mac_clr(b_mac_clr), .mac_en(b_mac_en), .acc_wr(b_acc_wr),
    .h_index(b_h_index), .busy(b_busy), .done(b_done));

  // Sample-counter models: P_stop flags the s_len-th enabled sample.
  int   s_len = 10;
  logic pstop_force = 1'b0;
  int   p_cnt = 0, b_cnt = 0;
  always_ff @(posedge clk) begin
    if (rst || rst_P) p_cnt <= 0;
    else if (en_P)    p_cnt <= p_cnt + 1;
    if (rst || b_rst_P) b_cnt <= 0;
    else if (b_en_P)    b_cnt <= b_cnt + 1;
  end
  assign P_stop  = (p_cnt == s_len - 1) || pstop_force;
  assign b_pstop = (b_cnt == 0);

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare every output of the selected instance against the expected vector.
  task automatic chk_out(input string tag, input bit b, input logic e_en, input logic e_rp,
                         input logic e_clr, input logic e_me, input logic e_wr,
                         input int e_h, input logic e_busy, input logic e_done);
    chk({tag, "/en_P"},    32'(b ? b_en_P    : en_P),    32'(e_en));
    chk({tag, "/rst_P"},   32'(b ? b_rst_P   : rst_P),   32'(e_rp));
    chk({tag, "/mac_clr"}, 32'(b ? b_mac_clr : mac_clr), 32'(e_clr));
    chk({tag, "/mac_en"},  32'(b ? b_mac_en  : mac_en),  32'(e_me));
    chk({tag, "/acc_wr"},  32'(b ? b_acc_wr  : acc_wr),  32'(e_wr));
    chk({tag, "/h_index"}, 32'(b ? b_h_index : h_index), 32'(e_h));
    chk({tag, "/busy"},    32'(b ? b_busy    : busy),    32'(e_busy));
    chk({tag, "/done"},    32'(b ? b_done    : done),    32'(e_done));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1; chk_out(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick;
    end
  endtask

  // Reference loop: the phase sequence CLR, RUN(s consumed samples), DRAIN, WRITE
  // per neuron then DONE, with hold/stray/abort/reset stimulus injected.
  task automatic run_loop(input int s, input int hold_pct, input int hold_h, input bit stray,
                          input int kill_h, input bit kill_rst);
    int  holds, macs, obs_mac, burst;
    bit  killed, hv;
    s_len = s; holds = 0; burst = 0; killed = 0;
    start = 1; #1; chk_out("idle_pre", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc = 0; tick; start = 0;
    for (int h = 0; h < NH && !killed; h++) begin
      start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      pstop_force = stray;
      #1; chk_out("clr", 0, 0, 1, 1, 0, 0, h, 1, 0); tick;
      pstop_force = 0;
      macs = 0; obs_mac = 0;
      while (macs < s && !killed) begin
        if (h == hold_h && macs == 4 && burst < 5) begin hv = 1; burst++; end
        else hv = (macs > 0) && ($urandom_range(0, 99) < hold_pct);
        hold = hv;
        start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        if (kill_rst && h == kill_h && macs == 3) begin
          hold = 0; rst = 1;
          #1; chk_out("run_at_rst", 0, 1, 0, 0, 1, 0, h, 1, 0); tick;
          #1; chk_out("rst_edge1", 0, 0, 0, 0, 0, 0, 0, 0, 0); tick;
          rst = 0;
          #1; chk_out("rst_edge2", 0, 0, 0, 0, 0, 0, 0, 0, 0); tick;
          killed = 1;
        end else begin
          #1; chk_out("run", 0, !hv, 0, 0, !hv, 0, h, 1, 0);
          obs_mac += int'(mac_en);
          if (hv) holds++; else macs++;
          tick;
        end
      end
      hold = 0;
      if (!killed) begin
        chk("mac_count", 32'(obs_mac), 32'(s));
        for (int d = 0; d < DL && !killed; d++) begin
          start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
          if (!kill_rst && h == kill_h && d == 0) abort = 1;
          #1; chk_out("drain", 0, 0, 0, 0, 0, 0, h, 1, 0); tick;
          if (abort) begin
            abort = 0; start = 0;
            #1; chk_out("abort_idle", 0, 0, 1, 0, 0, 0, 0, 0, 0); tick;
            idle_cycles("post_abort", 6);
            killed = 1;
          end
        end
      end
      if (!killed) begin
        start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        pstop_force = stray;
        #1; chk_out("write", 0, 0, 0, 0, 0, 1, h, 1, 0); tick;
        pstop_force = 0;
      end
    end
    if (!killed) begin
      start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      #1; chk_out("done", 0, 0, 0, 0, 0, 0, NH - 1, 1, 1);
      chk("done_time", done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(2 + NH * (2 + s + DL) - 1 + holds));
      tick; start = 0;
      idle_cycles("idle_post", 2);
    end
  endtask

  initial begin
    tick; tick;
    #1; chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("reset_b", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 0; tick;

    run_loop(10, 0, -1, 0, -1, 0);   // basic loop
    run_loop(10, 0, 1, 0, -1, 0);    // 5-cycle hold in neuron 1
    run_loop(10, 0, -1, 0, 2, 0);    // abort in DRAIN of neuron 2
    run_loop(10, 0, -1, 0, -1, 0);   // restart after abort
    run_loop(10, 0, -1, 1, -1, 0);   // stray start / P_stop
    run_loop(10, 0, -1, 0, 3, 1);    // reset mid-RUN of neuron 3
    pstop_force = 1;
    idle_cycles("post_rst_idle", 5);
    pstop_force = 0;
    for (int r = 0; r < 4; r++)
      run_loop(int'($urandom_range(1, 12)), 30, -1, r[0], -1, 0);

    // Boundary instance: NUM_HIDDEN=1, MAC_LAT=0, one sample.
    b_start = 1; #1; chk_out("b_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc = 0; tick; b_start = 0;
    #1; chk_out("b_clr", 1, 0, 1, 1, 0, 0, 0, 1, 0); tick;
    #1; chk_out("b_run", 1, 1, 0, 0, 1, 0, 0, 1, 0); tick;
    #1; chk_out("b_drain", 1, 0, 0, 0, 0, 0, 0, 1, 0); tick;
    #1; chk_out("b_write", 1, 0, 0, 0, 0, 1, 0, 1, 0); tick;
    #1; chk_out("b_done", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("b_done_time", b_done ? 32'(cyc) : 32'hFFFF_FFFF, 32'd5); tick;
    #1; chk_out("b_idle_post", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
